image_frame_serializer: RTL and testbench
=========================================

Name: image_frame_serializer

Overview:
- Transmit side of the 1024-bit image frame interface used between image loading and the TrafficSignal/TrafficSystem blocks.
- Accepts one complete 32x32 binary frame in parallel and streams it out as 32 row beats over a valid/ready interface.
- Feeds frames to file/dump logic and to any downstream row-serial consumer.
- Bit order matches the %b text image format: the first character in the file is bit 1023.

Parameters:
- ROWS, 32, number of rows per frame
- COLS, 32, pixels per row; frame width = ROWS*COLS
- IDXW, 5, row index width, must equal clog2(ROWS)

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- img_data  input  ROWS*COLS  parallel frame, row 0 = bits [ROWS*COLS-1 -: COLS]
- img_valid  input  1  frame present on img_data
- img_ready  output  1  serializer can capture a frame
- row_data  output  COLS  current row beat
- row_idx  output  IDXW  index of current row beat
- row_valid  output  1  row beat valid
- row_ready  input  1  downstream accepts beat
- sof  output  1  high with beat 0 of a frame
- eof  output  1  high with the final beat of a frame
- busy  output  1  frame in progress
- frame_cnt  output  8  completed frames, wraps 255->0

Behaviour:
- Reset values (rst sampled high at posedge):
  - img_ready=0 during the reset cycle, 1 from the first cycle after rst deasserts.
  - row_valid=0, row_data=0, row_idx=0, sof=0, eof=0, busy=0, frame_cnt=0.
- States:
  - IDLE: img_ready=1. On img_valid&&img_ready, latch img_data into the frame register, set row_idx=0, go to SEND.
  - SEND: img_ready=0, busy=1, row_valid=1.
  - DONE: internal only, used only when the trailer beat is enabled.
- Latency: capture at edge N; row 0 valid in the cycle after edge N.
- Row selection: row_data = frame_reg[ROWS*COLS-1-COLS*row_idx -: COLS], registered.
- Handshake:
  - A beat transfers on row_valid&&row_ready.
  - While row_valid&&!row_ready, row_data, row_idx, sof and eof hold stable.
  - row_valid never drops without a transfer.
- Flags: sof=1 only when row_idx==0 in SEND. eof=1 only on the last beat.
- Advance: each transfer increments row_idx.
  - On transfer of row ROWS-1 (no trailer): frame_cnt+=1, go to IDLE.
  - img_ready=1 in the following cycle; minimum gap between frames is 1 cycle.
- Input stability: img_data/img_valid changes after capture are ignored until back in IDLE.
- img_valid held high across frames: the next frame is captured on the first IDLE cycle.
- row_ready held high: 32 beats in 32 consecutive cycles.
- Reset mid-frame: the frame is discarded; all outputs return to reset values next cycle; frame_cnt is not incremented.

Optional Feature:
- Macro: FRAME_POPCOUNT_EN
- Defined:
  - After row ROWS-1 transfers, the block enters DONE and emits one extra beat.
  - Trailer beat: row_valid=1, row_idx=0, sof=0, eof=1, row_data = zero-extended count of '1' pixels in the frame (11 bits, max 1024).
  - The count accumulates per transferred row.
  - eof is NOT asserted on row ROWS-1.
  - frame_cnt increments on transfer of the trailer beat; then return to IDLE.
- Undefined: no DONE state, no accumulator, eof on row ROWS-1.

Test Plan:
- Reset then single frame:
  - Stimulus: img_data = {32'hFFFF_FFFF, 31 rows of 0}, row_ready=1.
  - Response: row 0 = FFFFFFFF with sof=1 one cycle after capture; rows 1-31 = 0; eof on idx 31; frame_cnt=1; img_ready=1 next cycle.
- Backpressure:
  - Stimulus: alternating-row pattern AAAAAAAA/55555555; row_ready low for 3 cycles at row 5.
  - Response: row_data=55555555 and row_idx=5 held stable for 3 cycles; no beat lost or duplicated; 32 beats total.
- Back-to-back frames:
  - Stimulus: img_valid held high with frames F1, F2 (F2 applied after F1 capture).
  - Response: F2 captured exactly 1 cycle after F1's eof transfer; frame_cnt=2; an img_data change during F1 does not alter F1 rows.
- Reset mid-frame:
  - Stimulus: assert rst after row 10 transfers.
  - Response: next cycle row_valid=0, busy=0, frame_cnt unchanged; a new frame afterwards starts at row_idx=0 with sof=1.
- frame_cnt wrap:
  - Stimulus: send 256 frames.
  - Response: frame_cnt reads 0 after the 256th eof.
- FRAME_POPCOUNT_EN:
  - Stimulus: all-ones frame, then a frame with 7 pixels set.
  - Response: trailer beats 32'h00000400 and 32'h00000007, each with eof=1; row 31 has eof=0.

Source files
------------

// File: rtl/image_frame_serializer.sv
// Serializes one parallel ROWS x COLS binary frame into ROWS row beats over valid/ready.
// Optional FRAME_POPCOUNT_EN appends a trailer beat carrying the frame's set-pixel count.
module image_frame_serializer #(
  parameter int ROWS = 32,
  parameter int COLS = 32,
  parameter int IDXW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS*COLS-1:0] img_data,
  input  logic                 img_valid,
  output logic                 img_ready,
  output logic [COLS-1:0]      row_data,
  output logic [IDXW-1:0]      row_idx,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic                 sof,
  output logic                 eof,
  output logic                 busy,
  output logic [7:0]           frame_cnt
);
  // state | meaning
  // IDLE  | waiting for a frame, img_ready high once out of reset
  // SEND  | streaming rows 0..ROWS-1
  // DONE  | popcount trailer beat on the bus (FRAME_POPCOUNT_EN only)
`ifdef FRAME_POPCOUNT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} state_t;
  localparam int CNTW = $clog2(ROWS*COLS+1);
  logic [CNTW-1:0] acc;

  function automatic logic [CNTW-1:0] ones(input logic [COLS-1:0] v);
    logic [CNTW-1:0] c;
    c = '0;
    for (int i = 0; i < COLS; i++) c = c + CNTW'(v[i]);
    return c;
  endfunction
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  localparam logic [IDXW-1:0] LAST = IDXW'(ROWS-1);

  state_t                 state, state_nxt;
  logic [ROWS*COLS-1:0]   frame_reg;
  logic                   ready_en;
  logic                   capture, xfer, last;
  logic [IDXW-1:0]        nidx;

  function automatic logic [COLS-1:0] pick_row(input logic [ROWS*COLS-1:0] f,
                                               input logic [IDXW-1:0] idx);
    return f[ROWS*COLS-1-COLS*int'(idx) -: COLS];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    img_ready = (state == IDLE) && ready_en;
    capture   = img_ready && img_valid;
    xfer      = row_valid && row_ready;
    last      = (row_idx == LAST);
    nidx      = row_idx + 1'b1;
    case (state)
      IDLE: if (capture) state_nxt = SEND;
`ifdef FRAME_POPCOUNT_EN
      SEND: if (xfer && last) state_nxt = DONE;
      DONE: if (xfer) state_nxt = IDLE;
`else
      SEND: if (xfer && last) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en  <= 1'b0;
      row_data  <= '0;
      row_idx   <= '0;
      row_valid <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
`ifdef FRAME_POPCOUNT_EN
      acc       <= '0;
`endif
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: if (capture) begin
          frame_reg <= img_data;
          row_data  <= img_data[ROWS*COLS-1 -: COLS];
          row_idx   <= '0;
          row_valid <= 1'b1;
          sof       <= 1'b1;
          eof       <= 1'b0;
          busy      <= 1'b1;
`ifdef FRAME_POPCOUNT_EN
          acc       <= '0;
`endif
        end
        SEND: if (xfer) begin
`ifdef FRAME_POPCOUNT_EN
          acc <= acc + ones(row_data);
`endif
          if (last) begin
`ifdef FRAME_POPCOUNT_EN
            // trailer reuses the bus with idx 0; count includes this final row
            row_data <= COLS'(acc + ones(row_data));
            row_idx  <= '0;
            sof      <= 1'b0;
            eof      <= 1'b1;
`else
            row_valid <= 1'b0;
            busy      <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
            row_data  <= '0;
            row_idx   <= '0;
            frame_cnt <= frame_cnt + 8'd1;
`endif
          end else begin
            row_idx  <= nidx;
            row_data <= pick_row(frame_reg, nidx);
            sof      <= 1'b0;
`ifdef FRAME_POPCOUNT_EN
            eof      <= 1'b0;
`else
            eof      <= (nidx == LAST);
`endif
          end
        end
`ifdef FRAME_POPCOUNT_EN
        DONE: if (xfer) begin
          row_valid <= 1'b0;
          busy      <= 1'b0;
          eof       <= 1'b0;
          row_data  <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_image_frame_serializer.sv
// Directed self-checking bench for image_frame_serializer; adapts to FRAME_POPCOUNT_EN.
module tb_image_frame_serializer;
  localparam int ROWS = 32;
`ifdef FRAME_POPCOUNT_EN
  localparam int NB = 33;
`else
  localparam int NB = 32;
`endif

  logic          clk, rst, img_valid, img_ready, row_valid, row_ready, sof, eof, busy;
  logic [1023:0] img_data;
  logic [31:0]   row_data;
  logic [4:0]    row_idx;
  logic [7:0]    frame_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] bd [0:63];
  logic [4:0]  bi [0:63];
  logic        bs [0:63];
  logic        be [0:63];
  logic [31:0] sd [0:7];
  logic [4:0]  si [0:7];
  int nb, ncyc, ns;

  image_frame_serializer dut (
    .clk(clk), .rst(rst), .img_data(img_data), .img_valid(img_valid), .img_ready(img_ready),
    .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid), .row_ready(row_ready),
    .sof(sof), .eof(eof), .busy(busy), .frame_cnt(frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [1023:0] ramp(input logic [31:0] base);
    logic [1023:0] f;
    for (int r = 0; r < ROWS; r++) f[1023-32*r -: 32] = base + 32'(r);
    return f;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; img_valid = 1'b0; row_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // called at a negedge; returns at the negedge after the capture edge
  task automatic start_frame(input logic [1023:0] f);
    int w;
    w = 0;
    while (!img_ready && w < 20) begin @(negedge clk); w++; end
    checks++; if (img_ready !== 1'b1) begin errors++; $display("FAIL start_frame_ready: got %b want 1", img_ready); end
    img_data = f; img_valid = 1'b1;
    @(posedge clk); #1 img_valid = 1'b0;
    @(negedge clk);
  endtask

  // records beats until the eof transfer; optional stall on one row index
  task automatic collect(input int stall_at, input int stall_len);
    int stalled;
    bit done;
    nb = 0; ns = 0; ncyc = 0; stalled = 0; done = 0;
    while (!done && ncyc < 200) begin
      ncyc++;
      if (row_valid && row_idx == 5'(stall_at) && stalled < stall_len) begin
        row_ready = 1'b0; stalled++;
        if (ns < 8) begin sd[ns] = row_data; si[ns] = row_idx; ns++; end
      end else row_ready = 1'b1;
      if (row_valid && row_ready) begin
        if (nb < 64) begin bd[nb] = row_data; bi[nb] = row_idx; bs[nb] = sof; be[nb] = eof; end
        nb++;
        if (eof) done = 1;
      end
      if (!done) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; img_valid = 1'b0; row_ready = 1'b0; img_data = '0;
    @(posedge clk); @(negedge clk);
    checks++; if (img_ready !== 1'b0) begin errors++; $display("FAIL rst_img_ready: got %b want 0", img_ready); end
    checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL rst_row_valid: got %b want 0", row_valid); end
    checks++; if (row_data !== 32'h0) begin errors++; $display("FAIL rst_row_data: got %h want 0", row_data); end
    checks++; if (row_idx !== 5'd0) begin errors++; $display("FAIL rst_row_idx: got %0d want 0", row_idx); end
    checks++; if ({sof, eof, busy} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {sof, eof, busy}); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (img_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", img_ready); end
  endtask

  task automatic test_single();
    logic [31:0] exp_d;
    apply_reset();
    row_ready = 1'b1;
    start_frame({32'hFFFF_FFFF, 992'b0});
    checks++; if ({row_valid, sof, busy, img_ready} !== 4'b1110) begin errors++; $display("FAIL single_first_flags: got %b want 1110", {row_valid, sof, busy, img_ready}); end
    checks++; if (row_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL single_row0: got %h want ffffffff", row_data); end
    collect(0, 0);
    checks++; if (nb !== NB) begin errors++; $display("FAIL single_beats: got %0d want %0d", nb, NB); end
    checks++; if (ncyc !== NB) begin errors++; $display("FAIL single_cycles: got %0d want %0d", ncyc, NB); end
    for (int r = 0; r < ROWS; r++) begin
      exp_d = (r == 0) ? 32'hFFFF_FFFF : 32'h0;
      checks++; if (bd[r] !== exp_d || bi[r] !== 5'(r)) begin errors++; $display("FAIL single_row%0d: got %h/%0d want %h/%0d", r, bd[r], bi[r], exp_d, r); end
      checks++; if (bs[r] !== (r == 0) || be[r] !== (r == ROWS-1 && NB == ROWS)) begin errors++; $display("FAIL single_flags%0d: got sof=%b eof=%b", r, bs[r], be[r]); end
    end
    @(negedge clk);
    checks++; if ({img_ready, row_valid, busy} !== 3'b100) begin errors++; $display("FAIL single_after: got %b want 100", {img_ready, row_valid, busy}); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_backpressure();
    logic [1023:0] f;
    logic [31:0] exp_d;
    for (int r = 0; r < ROWS; r++) f[1023-32*r -: 32] = (r % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
    apply_reset();
    start_frame(f);
    collect(5, 3);
    checks++; if (nb !== NB) begin errors++; $display("FAIL bp_beats: got %0d want %0d", nb, NB); end
    checks++; if (ncyc !== NB + 3) begin errors++; $display("FAIL bp_cycles: got %0d want %0d", ncyc, NB + 3); end
    checks++; if (ns !== 3) begin errors++; $display("FAIL bp_stalls: got %0d want 3", ns); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (sd[k] !== 32'h5555_5555 || si[k] !== 5'd5) begin errors++; $display("FAIL bp_hold%0d: got %h/%0d want 55555555/5", k, sd[k], si[k]); end
    end
    for (int r = 0; r < ROWS; r++) begin
      exp_d = (r % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
      checks++; if (bd[r] !== exp_d || bi[r] !== 5'(r)) begin errors++; $display("FAIL bp_row%0d: got %h/%0d want %h/%0d", r, bd[r], bi[r], exp_d, r); end
    end
    @(negedge clk);
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL bp_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    img_data = ramp(32'hA100_0000); img_valid = 1'b1;
    @(posedge clk); #1 img_data = ramp(32'hB200_0000);
    @(negedge clk);
    collect(0, 0);
    for (int r = 0; r < ROWS; r++) begin
      checks++; if (bd[r] !== 32'hA100_0000 + 32'(r)) begin errors++; $display("FAIL b2b_f1_row%0d: got %h want %h", r, bd[r], 32'hA100_0000 + 32'(r)); end
    end
    @(negedge clk);
    checks++; if ({img_ready, row_valid} !== 2'b10) begin errors++; $display("FAIL b2b_gap: got %b want 10", {img_ready, row_valid}); end
    @(posedge clk); #1 img_valid = 1'b0;
    @(negedge clk);
    checks++; if ({row_valid, sof, row_idx} !== {2'b11, 5'd0}) begin errors++; $display("FAIL b2b_f2_start: got %b/%b/%0d want 1/1/0", row_valid, sof, row_idx); end
    checks++; if (row_data !== 32'hB200_0000 || frame_cnt !== 8'd1) begin errors++; $display("FAIL b2b_f2_row0: got %h cnt %0d want b2000000 cnt 1", row_data, frame_cnt); end
    collect(0, 0);
    for (int r = 0; r < ROWS; r++) begin
      checks++; if (bd[r] !== 32'hB200_0000 + 32'(r)) begin errors++; $display("FAIL b2b_f2_row%0d: got %h want %h", r, bd[r], 32'hB200_0000 + 32'(r)); end
    end
    @(negedge clk);
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL b2b_cnt: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    int w;
    apply_reset();
    row_ready = 1'b1;
    start_frame(ramp(32'hC300_0000));
    w = 0;
    while (row_idx !== 5'd10 && w < 40) begin @(negedge clk); w++; end
    checks++; if (row_idx !== 5'd10) begin errors++; $display("FAIL mid_reach10: got %0d want 10", row_idx); end
    @(negedge clk);
    checks++; if (row_idx !== 5'd11 || row_data !== 32'hC300_000B) begin errors++; $display("FAIL mid_row11: got %0d/%h want 11/c300000b", row_idx, row_data); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({row_valid, busy, sof, eof, img_ready} !== 5'b00000) begin errors++; $display("FAIL mid_flags: got %b want 00000", {row_valid, busy, sof, eof, img_ready}); end
    checks++; if (frame_cnt !== 8'd0 || row_idx !== 5'd0 || row_data !== 32'h0) begin errors++; $display("FAIL mid_regs: got cnt %0d idx %0d data %h", frame_cnt, row_idx, row_data); end
    rst = 1'b0;
    @(negedge clk);
    start_frame(ramp(32'hD400_0000));
    checks++; if ({row_valid, sof, row_idx} !== {2'b11, 5'd0} || row_data !== 32'hD400_0000) begin errors++; $display("FAIL mid_restart: got %b/%b/%0d/%h", row_valid, sof, row_idx, row_data); end
    collect(0, 0);
    @(negedge clk);
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL mid_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_wrap();
    int n, cyc;
    apply_reset();
    img_data = ramp(32'h0); img_valid = 1'b1; row_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 256 && cyc < 256 * 40) begin
      @(negedge clk); cyc++;
      if (row_valid && eof) begin
        n++;
        if (n == 255) begin
          @(negedge clk); cyc++;
          checks++; if (frame_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", frame_cnt); end
        end else if (n == 256) begin
          @(negedge clk);
          img_valid = 1'b0;
          checks++; if (frame_cnt !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL wrap_0: got cnt %0d busy %b want 0/0", frame_cnt, busy); end
        end
      end
    end
    img_valid = 1'b0;
    checks++; if (n !== 256) begin errors++; $display("FAIL wrap_frames: got %0d want 256", n); end
  endtask

`ifdef FRAME_POPCOUNT_EN
  task automatic test_popcount();
    logic [1023:0] f;
    apply_reset();
    start_frame({1024{1'b1}});
    collect(0, 0);
    checks++; if (nb !== 33) begin errors++; $display("FAIL pc_beats: got %0d want 33", nb); end
    checks++; if (bd[32] !== 32'h0000_0400 || be[32] !== 1'b1) begin errors++; $display("FAIL pc_trailer1: got %h eof %b want 00000400/1", bd[32], be[32]); end
    checks++; if (bi[32] !== 5'd0 || bs[32] !== 1'b0) begin errors++; $display("FAIL pc_trailer_idx: got %0d sof %b want 0/0", bi[32], bs[32]); end
    checks++; if (be[31] !== 1'b0 || bd[31] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL pc_row31: got %h eof %b want ffffffff/0", bd[31], be[31]); end
    @(negedge clk);
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL pc_cnt1: got %0d want 1", frame_cnt); end
    f = '0;
    f[1023] = 1'b1; f[1000] = 1'b1; f[512] = 1'b1; f[511] = 1'b1;
    f[100] = 1'b1; f[31] = 1'b1; f[0] = 1'b1;
    start_frame(f);
    collect(0, 0);
    checks++; if (bd[32] !== 32'h0000_0007 || be[32] !== 1'b1) begin errors++; $display("FAIL pc_trailer2: got %h eof %b want 00000007/1", bd[32], be[32]); end
    checks++; if (be[31] !== 1'b0) begin errors++; $display("FAIL pc_row31_b: got eof %b want 0", be[31]); end
    @(negedge clk);
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL pc_cnt2: got %0d want 2", frame_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1; img_valid = 1'b0; row_ready = 1'b0; img_data = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
`ifdef FRAME_POPCOUNT_EN
    test_popcount();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
